// File: rtl/change_dispenser.sv
// change_dispenser: pays a 5-bit change amount out as single coins, largest
// denomination first (TEN, FIVE, ONE), through a valid/ack handshake with the
// coin-ejection mechanism. Keeps per-denomination inventory counters and
// raises a sticky shortfall flag when exact change cannot be made.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start/change_in request to pay change_in (taken only when idle)
//   restock         reload all inventories (taken only when idle, start wins)
//   coin_ack        mechanism has ejected the presented coin
//   coin_valid/type coin request (type 0 none, 1 ONE, 2 FIVE, 3 TEN)
//   busy/done/short transaction status (done is a 1-cycle pulse, short sticky)
//   remaining       amount still owed
//   inv_ten/five/one coins on hand
module change_dispenser #(
  parameter int INV_W     = 4,
  parameter int INIT_TEN  = 8,
  parameter int INIT_FIVE = 8,
  parameter int INIT_ONE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       change_in,
  input  logic             restock,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [4:0]       remaining,
  output logic [INV_W-1:0] inv_ten,
  output logic [INV_W-1:0] inv_five,
  output logic [INV_W-1:0] inv_one
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_DISPENSE, S_DONE, S_FAULT
  } state_t;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_ONE  = 2'd1;
  localparam logic [1:0] C_FIVE = 2'd2;
  localparam logic [1:0] C_TEN  = 2'd3;

  localparam logic [INV_W-1:0] LD_TEN  = INV_W'(INIT_TEN);
  localparam logic [INV_W-1:0] LD_FIVE = INV_W'(INIT_FIVE);
  localparam logic [INV_W-1:0] LD_ONE  = INV_W'(INIT_ONE);
  localparam logic [INV_W-1:0] DEC     = INV_W'(1);

  // every output is a field of this registered bundle
  typedef struct packed {
    state_t           state;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             busy;
    logic             done;
    logic             short;
    logic [4:0]       remaining;
    logic [INV_W-1:0] inv_ten;
    logic [INV_W-1:0] inv_five;
    logic [INV_W-1:0] inv_one;
  } regs_t;

  regs_t r, nx;

  function automatic logic [4:0] denom(input logic [1:0] t);
    case (t)
      C_TEN:   denom = 5'd10;
      C_FIVE:  denom = 5'd5;
      C_ONE:   denom = 5'd1;
      default: denom = 5'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '{state: S_IDLE, coin_valid: 1'b0, coin_type: C_NONE, busy: 1'b0,
             done: 1'b0, short: 1'b0, remaining: 5'd0,
             inv_ten: LD_TEN, inv_five: LD_FIVE, inv_one: LD_ONE};
    end else begin
      r <= nx;
    end
  end

  always_comb begin
    nx      = r;
    nx.done = 1'b0;
    case (r.state)
      S_IDLE: begin
        if (start) begin
          nx.remaining = change_in;
          nx.busy      = 1'b1;
          nx.short     = 1'b0;
          nx.state     = (change_in == 5'd0) ? S_DONE : S_SELECT;
        end else if (restock) begin
          nx.inv_ten  = LD_TEN;
          nx.inv_five = LD_FIVE;
          nx.inv_one  = LD_ONE;
        end
      end
      S_SELECT: begin
        // remaining is nonzero here, so a failed search means a real shortfall
        nx.coin_valid = 1'b1;
        nx.state      = S_DISPENSE;
        if (r.remaining >= 5'd10 && r.inv_ten != '0)      nx.coin_type = C_TEN;
        else if (r.remaining >= 5'd5 && r.inv_five != '0) nx.coin_type = C_FIVE;
        else if (r.inv_one != '0)                         nx.coin_type = C_ONE;
        else begin
          nx.coin_valid = 1'b0;
          nx.short      = 1'b1;
          nx.state      = S_FAULT;
        end
      end
      S_DISPENSE: begin
        if (coin_ack) begin
          nx.remaining  = r.remaining - denom(r.coin_type);
          nx.coin_valid = 1'b0;
          nx.coin_type  = C_NONE;
          case (r.coin_type)
            C_TEN:   nx.inv_ten  = r.inv_ten - DEC;
            C_FIVE:  nx.inv_five = r.inv_five - DEC;
            C_ONE:   nx.inv_one  = r.inv_one - DEC;
            default: ;
          endcase
          nx.state = (nx.remaining == 5'd0) ? S_DONE : S_SELECT;
        end
      end
      S_DONE: begin
        nx.done  = 1'b1;
        nx.busy  = 1'b0;
        nx.state = S_IDLE;
      end
      S_FAULT: begin
        nx.busy  = 1'b0;
        nx.state = S_IDLE;
      end
      default: nx.state = S_IDLE;
    endcase
  end

  assign coin_valid = r.coin_valid;
  assign coin_type  = r.coin_type;
  assign busy       = r.busy;
  assign done       = r.done;
  assign short      = r.short;
  assign remaining  = r.remaining;
  assign inv_ten    = r.inv_ten;
  assign inv_five   = r.inv_five;
  assign inv_one    = r.inv_one;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: expected coins and end-of-transaction state are
// queued by the stimulus; a mechanism/monitor process acks coins and compares.
module tb_change_dispenser;

  logic       clk, rst;
  logic       start, restock, coin_ack;
  logic [4:0] change_in;
  logic       coin_valid, busy, done, short;
  logic [1:0] coin_type;
  logic [4:0] remaining;
  logic [3:0] inv_ten, inv_five, inv_one;

  logic       start2, restock2, ack2;
  logic [4:0] change2;
  logic       cv2, busy2, done2, short2;
  logic [1:0] ct2;
  logic [4:0] rem2;
  logic [3:0] it2, if2, io2;

  change_dispenser u_dut (
    .clk(clk), .rst(rst), .start(start), .change_in(change_in),
    .restock(restock), .coin_ack(coin_ack), .coin_valid(coin_valid),
    .coin_type(coin_type), .busy(busy), .done(done), .short(short),
    .remaining(remaining), .inv_ten(inv_ten), .inv_five(inv_five),
    .inv_one(inv_one));

  change_dispenser #(.INIT_ONE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .change_in(change2),
    .restock(restock2), .coin_ack(ack2), .coin_valid(cv2),
    .coin_type(ct2), .busy(busy2), .done(done2), .short(short2),
    .remaining(rem2), .inv_ten(it2), .inv_five(if2), .inv_one(io2));

  typedef struct { int rem; int t; int f; int o; } rec_t;

  int   errors = 0, checks = 0, ndone = 0;
  bit   ack_en = 1'b1;
  int   exp_coins[$];
  rec_t exp_done[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_rec(input int rm, input int t, input int f, input int o);
    rec_t e;
    e.rem = rm; e.t = t; e.f = f; e.o = o;
    exp_done.push_back(e);
  endtask

  // mechanism model + monitor: acks each presented coin once, checks its type,
  // and checks the state reported alongside each done pulse
  initial begin
    coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && coin_valid && !coin_ack) begin
        if (exp_coins.size() == 0) chk("coin_unexpected", 1, 0);
        else chk("coin_type", int'(coin_type), exp_coins.pop_front());
        coin_ack = 1'b1;
      end else begin
        coin_ack = 1'b0;
      end
      if (done) begin
        rec_t e;
        ndone++;
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_done.pop_front();
          chk("done_remaining", int'(remaining), e.rem);
          chk("done_inv_ten", int'(inv_ten), e.t);
          chk("done_inv_five", int'(inv_five), e.f);
          chk("done_inv_one", int'(inv_one), e.o);
        end
      end
    end
  end

  task automatic wait_valid();
    int k = 0;
    while (!coin_valid && k < 20) begin @(negedge clk); k++; end
    if (!coin_valid) chk("coin_valid_timeout", 0, 1);
  endtask

  task automatic finish_txn(input int n0);
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) chk("busy_timeout", 1, 0);
    @(negedge clk);
    chk("done_count", ndone - n0, 1);
    chk("done_low", int'(done), 0);
    chk("coins_left", exp_coins.size(), 0);
  endtask

  task automatic run(input logic [4:0] amt);
    int n0 = ndone;
    change_in = amt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_txn(n0);
  endtask

  task automatic drain2(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy2) break;
      if (cv2 && !ack2) begin
        chk("dut2_coin_type", int'(ct2), 1);
        ack2 = 1'b1; n++;
      end else ack2 = 1'b0;
      @(negedge clk);
    end
    ack2 = 1'b0;
    if (busy2) chk("dut2_busy_timeout", 1, 0);
  endtask

  initial begin
    int n0, nc;
    rst = 1'b0; start = 1'b0; restock = 1'b0; change_in = 5'd0;
    start2 = 1'b0; restock2 = 1'b0; ack2 = 1'b0; change2 = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_coin_type", int'(coin_type), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_inv_ten", int'(inv_ten), 8);
    chk("rst_inv_five", int'(inv_five), 8);
    chk("rst_inv_one", int'(inv_one), 8);

    // 5 -> one FIVE
    exp_coins.push_back(2);
    push_rec(0, 8, 7, 8);
    run(5'd5);

    // reset while a coin is presented
    ack_en = 1'b0;
    change_in = 5'd18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    chk("midrst_type_before", int'(coin_type), 3);
    rst = 1'b0;
    #1;
    chk("midrst_coin_valid", int'(coin_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_inv_five", int'(inv_five), 8);
    chk("midrst_remaining", int'(remaining), 0);
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);

    // 18 -> TEN FIVE ONE ONE ONE
    exp_coins.push_back(3); exp_coins.push_back(2);
    exp_coins.push_back(1); exp_coins.push_back(1); exp_coins.push_back(1);
    push_rec(0, 7, 7, 5);
    run(5'd18);

    // zero amount: done on the second edge, no coin
    push_rec(0, 7, 7, 5);
    n0 = ndone;
    change_in = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_edge1", int'(done), 0);
    chk("zero_busy_edge1", int'(busy), 1);
    @(negedge clk);
    chk("zero_done_edge2", int'(done), 1);
    chk("zero_busy_edge2", int'(busy), 0);
    @(negedge clk);
    chk("zero_done_count", ndone - n0, 1);
    chk("zero_done_low", int'(done), 0);

    // stalled ack and ignored start while busy: 7 -> FIVE ONE ONE
    ack_en = 1'b0;
    exp_coins.push_back(2); exp_coins.push_back(1); exp_coins.push_back(1);
    push_rec(0, 7, 6, 3);
    n0 = ndone;
    change_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_coin_valid", int'(coin_valid), 1);
      chk("stall_coin_type", int'(coin_type), 2);
      chk("stall_remaining", int'(remaining), 7);
      if (i == 3) begin change_in = 5'd20; start = 1'b1; end
      if (i == 4) start = 1'b0;
    end
    ack_en = 1'b1;
    finish_txn(n0);

    // shortfall on the INIT_ONE=2 instance
    change2 = 5'd3; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    drain2(nc);
    chk("short_coins", nc, 2);
    chk("short_flag", int'(short2), 1);
    chk("short_remaining", int'(rem2), 1);
    chk("short_inv_one", int'(io2), 0);
    chk("short_busy", int'(busy2), 0);
    chk("short_done", int'(done2), 0);
    restock2 = 1'b1;
    @(negedge clk);
    restock2 = 1'b0;
    @(negedge clk);
    chk("restock_inv_one", int'(io2), 2);
    chk("restock_short_held", int'(short2), 1);
    change2 = 5'd1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("restart_short_clear", int'(short2), 0);
    chk("restart_busy", int'(busy2), 1);
    drain2(nc);
    chk("restart_coins", nc, 1);
    chk("restart_inv_one", int'(io2), 1);

    chk("done_records_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
